// File: rtl/dmem_responder.sv
// dmem_responder
//   Handshaked data-memory slave for the core's load/store path. Takes one
//   request at a time (lw/sw/lb/sb), waits LATENCY cycles, then presents a
//   single response and holds it until the requester takes it.
//   Storage is DEPTH little-endian 32-bit words, byte addressed.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for a request; accept latches the request fields
//   WAIT  | counting down the latency; access executes when count hits 1
//   RESP  | response held on resp_* until resp_ready
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready request handshake
//   req_write       1 = store, 0 = load
//   req_byte        1 = byte access, 0 = word access
//   req_addr        byte address
//   req_wdata       store data (byte store uses [7:0])
//   resp_valid/ready response handshake
//   resp_rdata      load data (sign-extended for byte loads), 0 for stores/errors
//   resp_err        misaligned word access or address out of range

module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;

    logic        lat_write;
    logic        lat_byte;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] rdata_q;
    logic        err_q;

    // Contents start at zero and survive rst.
    logic [31:0] mem [DEPTH] = '{default: '0};

    logic          accept;
    logic          exec;
    logic          acc_write;
    logic          acc_byte;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [AW-1:0] acc_idx;
    logic [4:0]    lane_lsb;
    logic          acc_err;
    logic [31:0]   cur_word;
    logic [7:0]    cur_byte;

    assign accept = req_valid && (state == IDLE);

    // With LATENCY=0 the access happens on the accept edge itself, so the
    // request is taken straight from the inputs while IDLE.
    assign exec = ((state == WAIT) && (cnt == 4'd1)) ||
                  (accept && (LATENCY == 0));

    assign acc_write = (state == IDLE) ? req_write : lat_write;
    assign acc_byte  = (state == IDLE) ? req_byte  : lat_byte;
    assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;

    assign acc_idx  = acc_addr[AW+1:2];
    assign lane_lsb = {acc_addr[1:0], 3'b000};

    // Any set bit above the word index means addr >= 4*DEPTH.
    assign acc_err = (acc_addr[31:AW+2] != '0) ||
                     (!acc_byte && (acc_addr[1:0] != 2'b00));

    assign cur_word = mem[acc_idx];
    assign cur_byte = cur_word[lane_lsb +: 8];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        case (state)
            IDLE:    req_ready  = 1'b1;
            RESP:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request latch, latency counter, response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            lat_write <= 1'b0;
            lat_byte  <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                lat_write <= req_write;
                lat_byte  <= req_byte;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt       <= LAT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (exec) begin
                err_q <= acc_err;
                if (acc_err || acc_write) begin
                    rdata_q <= 32'd0;
                end else if (acc_byte) begin
                    rdata_q <= {{24{cur_byte[7]}}, cur_byte};
                end else begin
                    rdata_q <= cur_word;
                end
            end
        end
    end

    // Storage write; a reset on the execute edge discards the store.
    always_ff @(posedge clk) begin
        if (!rst && exec && !acc_err && acc_write) begin
            if (acc_byte) begin
                mem[acc_idx][lane_lsb +: 8] <= acc_wdata[7:0];
            end else begin
                mem[acc_idx] <= acc_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int LAT0 = 2;
    localparam int LAT1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic        req_byte   [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t  expq  [2][$];
    string nameq [2][$];
    int    accq  [2][$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(32), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_byte(req_byte[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH(32), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_byte(req_byte[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endfunction

    function automatic void fail(input string nm, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", nm, what);
    endfunction

    // Monitor: latency, stall stability and scoreboard comparison.
    initial begin : monitor
        logic        pv   [2];
        logic        pr   [2];
        logic [31:0] prd  [2];
        logic        perr [2];
        exp_t        e;
        string       nm;
        int          a;
        for (int d = 0; d < 2; d++) begin
            pv[d] = 1'b0; pr[d] = 1'b1; prd[d] = '0; perr[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    expq[d].delete();
                    nameq[d].delete();
                    accq[d].delete();
                    pv[d] = 1'b0;
                    pr[d] = 1'b1;
                end else begin
                    if (req_valid[d] && req_ready[d]) accq[d].push_back(cyc);
                    if (resp_valid[d]) begin
                        chk($sformatf("req_ready_in_resp_dut%0d", d), 32'(req_ready[d]), 32'd0);
                        if (!pv[d]) begin
                            if (accq[d].size() == 0) begin
                                fail($sformatf("latency_dut%0d", d), "response without accepted request");
                            end else begin
                                a = accq[d].pop_front();
                                chk($sformatf("latency_dut%0d", d), 32'(cyc - a),
                                    32'((d == 0) ? LAT0 + 1 : LAT1 + 1));
                            end
                        end else if (!pr[d]) begin
                            chk($sformatf("stall_rdata_dut%0d", d), resp_rdata[d], prd[d]);
                            chk($sformatf("stall_err_dut%0d", d), 32'(resp_err[d]), 32'(perr[d]));
                        end
                        if (resp_ready[d]) begin
                            if (expq[d].size() == 0) begin
                                fail($sformatf("unexpected_resp_dut%0d", d),
                                     $sformatf("rdata=%h err=%0d", resp_rdata[d], resp_err[d]));
                            end else begin
                                e  = expq[d].pop_front();
                                nm = nameq[d].pop_front();
                                chk({nm, "_rdata"}, resp_rdata[d], e.rdata);
                                chk({nm, "_err"}, 32'(resp_err[d]), 32'(e.err));
                            end
                        end
                    end
                    pv[d]   = resp_valid[d];
                    pr[d]   = resp_ready[d];
                    prd[d]  = resp_rdata[d];
                    perr[d] = resp_err[d];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int d, input bit w, input bit b, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input bit ee,
                         input string nm, output int acc);
        expq[d].push_back('{rdata: er, err: ee});
        nameq[d].push_back(nm);
        req_write[d] = w;
        req_byte[d]  = b;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready[d]) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) fail({nm, "_accept"}, "request not accepted within 100 cycles");
        @(posedge clk);
        #1;
        // Scramble the fields so a design that rereads them gets caught.
        req_valid[d] = 1'b0;
        req_write[d] = ~w;
        req_byte[d]  = ~b;
        req_addr[d]  = ~a;
        req_wdata[d] = ~wd;
    endtask

    task automatic wait_done(input int d, input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (expq[d].size() == 0) done = 1'b1;
        end
        if (!done) fail({nm, "_response"}, "no response within 100 cycles");
        step();
    endtask

    task automatic req(input int d, input bit w, input bit b, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input bit ee,
                       input string nm);
        int acc;
        issue(d, w, b, a, wd, er, ee, nm, acc);
        wait_done(d, nm);
    endtask

    task automatic check_reset(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_req_ready_dut%0d", nm, d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("%s_resp_valid_dut%0d", nm, d), 32'(resp_valid[d]), 32'd0);
            chk($sformatf("%s_resp_rdata_dut%0d", nm, d), resp_rdata[d], 32'd0);
            chk($sformatf("%s_resp_err_dut%0d", nm, d), 32'(resp_err[d]), 32'd0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int a1, a2;
        bit seen;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_byte[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; resp_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        step();
        check_reset("reset");

        // T1
        req(0, 1, 0, 32'h08, 32'hDEADBEEF, 32'h0, 0, "t1_sw");
        req(0, 0, 0, 32'h08, 32'h0, 32'hDEADBEEF, 0, "t1_lw");

        // T2
        req(0, 1, 0, 32'h10, 32'h11223344, 32'h0, 0, "t2_sw");
        req(0, 1, 1, 32'h12, 32'h123456AA, 32'h0, 0, "t2_sb");
        req(0, 0, 0, 32'h10, 32'h0, 32'h11AA3344, 0, "t2_lw");
        req(0, 0, 1, 32'h12, 32'h0, 32'hFFFFFFAA, 0, "t2_lb12");
        req(0, 0, 1, 32'h10, 32'h0, 32'h00000044, 0, "t2_lb10");
        req(0, 0, 1, 32'h13, 32'h0, 32'h00000011, 0, "t2_lb13");

        // T3
        req(0, 1, 0, 32'h00, 32'hCAFEF00D, 32'h0, 0, "t3_sw0");
        req(0, 0, 0, 32'h06, 32'h0, 32'h0, 1, "t3_lw_misaligned");
        req(0, 1, 0, 32'h80, 32'hFFFFFFFF, 32'h0, 1, "t3_sw_range");
        req(0, 0, 0, 32'h00, 32'h0, 32'hCAFEF00D, 0, "t3_lw0");
        req(0, 1, 0, 32'h02, 32'h12345678, 32'h0, 1, "t3_sw_misaligned");
        req(0, 0, 1, 32'h80, 32'h0, 32'h0, 1, "t3_lb_range");
        req(0, 1, 0, 32'h10000008, 32'h0, 32'h0, 1, "t3_sw_high");
        req(0, 0, 0, 32'h08, 32'h0, 32'hDEADBEEF, 0, "t3_lw8");
        req(0, 1, 1, 32'h7F, 32'hFFFFFF5A, 32'h0, 0, "t3_sb_last");
        req(0, 0, 1, 32'h7F, 32'h0, 32'h0000005A, 0, "t3_lb_last");
        req(0, 0, 0, 32'h7C, 32'h0, 32'h5A000000, 0, "t3_lw_last");

        // Back-to-back store then load of the same word
        issue(0, 1, 0, 32'h18, 32'h0BADF00D, 32'h0, 0, "b2b0_sw", a1);
        issue(0, 0, 0, 32'h18, 32'h0, 32'h0BADF00D, 0, "b2b0_lw", a2);
        chk("b2b0_interval", 32'(a2 - a1), 32'(LAT0 + 2));
        wait_done(0, "b2b0");

        // T4: response stall with an ignored request pulse
        resp_ready[0] = 1'b0;
        issue(0, 0, 0, 32'h08, 32'h0, 32'hDEADBEEF, 0, "t4_lw", a1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid[0]) seen = 1'b1;
        end
        if (!seen) fail("t4_resp_valid", "response never presented");
        step();
        req_write[0] = 1'b1; req_byte[0] = 1'b0; req_addr[0] = 32'h08;
        req_wdata[0] = 32'h0; req_valid[0] = 1'b1;
        step();
        req_valid[0] = 1'b0;
        repeat (3) step();
        resp_ready[0] = 1'b1;
        wait_done(0, "t4");
        req(0, 0, 0, 32'h08, 32'h0, 32'hDEADBEEF, 0, "t4_lw_after");

        // T5: reset during WAIT, and on the execute edge
        req(0, 1, 0, 32'h04, 32'h12345678, 32'h0, 0, "t5_sw");
        issue(0, 1, 0, 32'h04, 32'h00000005, 32'h0, 0, "t5_abort", a1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step();
        check_reset("t5_wait_rst");
        issue(0, 1, 0, 32'h04, 32'h00000077, 32'h0, 0, "t5_exec_rst", a1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step();
        check_reset("t5_exec_rst");
        req(0, 0, 0, 32'h04, 32'h0, 32'h12345678, 0, "t5_lw");

        // Request presented together with reset is not accepted
        rst = 1'b1;
        req_write[0] = 1'b1; req_byte[0] = 1'b0; req_addr[0] = 32'h0C;
        req_wdata[0] = 32'h00000BAD; req_valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        req_valid[0] = 1'b0;
        rst = 1'b0;
        repeat (4) step();
        check_reset("rst_valid");
        req(0, 0, 0, 32'h0C, 32'h0, 32'h0, 0, "rst_valid_lw");

        // T6: LATENCY=0 instance
        req(1, 1, 0, 32'h20, 32'hA5A5A5A5, 32'h0, 0, "t6_sw");
        req(1, 0, 0, 32'h20, 32'h0, 32'hA5A5A5A5, 0, "t6_lw");
        issue(1, 1, 0, 32'h24, 32'h01020304, 32'h0, 0, "t6_b2b_sw", a1);
        issue(1, 0, 0, 32'h24, 32'h0, 32'h01020304, 0, "t6_b2b_lw", a2);
        chk("t6_interval", 32'(a2 - a1), 32'(LAT1 + 2));
        wait_done(1, "t6_b2b");
        req(1, 0, 1, 32'h27, 32'h0, 32'h00000001, 0, "t6_lb");
        req(1, 0, 0, 32'h26, 32'h0, 32'h0, 1, "t6_lw_misaligned");

        repeat (5) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
